milestone_reporter: RTL and testbench

MILESTONE_REPORTER -- requirements
Module: milestone_reporter

---
 rtl/milestone_reporter.sv | 202 ++++++++++++++++++++
 tb/tb_milestone_reporter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/milestone_reporter.sv
// milestone_reporter: turns rising edges of an upstream milestone level into
// {seq, cnt} records, queues them in a small FIFO for a ready/valid consumer,
// checks the spacing between consecutive milestone counts, and reports when
// the upstream run has completed and every queued record has been drained.
module milestone_reporter #(
    parameter int CNT_W = 20,
    parameter int STEP  = 200000,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   cnt,
    input  logic               milestone,
    input  logic               done,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [CNT_W+2:0]   rec_data,
    output logic               overflow,
    output logic [7:0]         drop_cnt,
    output logic               seq_err,
    output logic               finished
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int REC_W = CNT_W + 3;

    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);
    localparam logic [CNT_W:0] STEP_C  = (CNT_W+1)'(STEP);

    // The FIFO pointers rely on natural wrap, so the depth must be 2^n.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("milestone_reporter: DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t state_q;
    logic   finished_q;

    // Edge-detect history and bookkeeping registers
    logic               ms_q, ms_d;
    logic               done_q, done_d;
    logic [2:0]         seq_q, seq_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic               seq_err_q, seq_err_d;

    // FIFO storage and pointers
    logic [REC_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;

    // Per-cycle decode
    logic               ev;
    logic               pop;
    logic               full;
    logic               push;
    logic               drop;
    logic [2:0]         seq_next;
    logic [REC_W-1:0]   rec_new;
    logic [CNT_W:0]     exp_cnt;
    logic               space_bad;
    logic               done_rise;

    assign rec_valid = (count_q != '0);
    // Gate the head with valid so the output reads zero whenever the queue is empty.
    assign rec_data  = rec_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign seq_err   = seq_err_q;
    assign finished  = finished_q;

    // Event decode, push/drop arbitration, spacing check and next-state values.
    always_comb begin
        ev         = milestone & ~ms_q & (state_q != FIN);
        pop        = rec_valid & rec_ready;
        full       = (count_q == DEPTH_C);
        push       = ev & (~full | pop);
        drop       = ev & full & ~pop;
        seq_next   = seq_q + 3'd1;
        rec_new    = {seq_next, cnt};
        // One extra bit so a sum past the counter range can never alias a valid count.
        exp_cnt    = {1'b0, last_q} + STEP_C;
        space_bad  = ({1'b0, cnt} != exp_cnt);
        done_rise  = done & ~done_q;

        ms_d       = milestone;
        done_d     = done;
        seq_d      = seq_q;
        last_d     = last_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        seq_err_d  = seq_err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        // Dropped events still advance seq and update last so gaps stay visible.
        if (ev) begin
            seq_d  = seq_next;
            last_d = cnt;
            if (space_bad) begin
                seq_err_d = 1'b1;
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Bookkeeping and FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ms_q       <= 1'b0;
            done_q     <= 1'b0;
            seq_q      <= 3'd0;
            last_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
            seq_err_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            ms_q       <= ms_d;
            done_q     <= done_d;
            seq_q      <= seq_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            seq_err_q  <= seq_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Record storage: written on push, contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= rec_new;
        end
    end

    // Run-completion FSM with a registered finished flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            finished_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (done_rise) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_q == '0 && !push) begin
                        state_q    <= FIN;
                        finished_q <= 1'b1;
                    end
                end
                FIN: begin
                    state_q    <= FIN;
                    finished_q <= 1'b1;
                end
                default: begin
                    state_q    <= RUN;
                    finished_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_milestone_reporter.sv
// Scoreboard bench for milestone_reporter: stimulus pushes the expected
// {seq, cnt} records, a negedge monitor pops and compares on every handshake.
module tb_milestone_reporter;

    localparam int CNT_W = 20;
    localparam int REC_W = CNT_W + 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [CNT_W-1:0]   cnt = '0;
    logic               milestone = 1'b0;
    logic               done = 1'b0;
    logic               rec_valid;
    logic               rec_ready = 1'b0;
    logic [REC_W-1:0]   rec_data;
    logic               overflow;
    logic [7:0]         drop_cnt;
    logic               seq_err;
    logic               finished;

    int                 checks = 0;
    int                 errors = 0;
    logic [REC_W-1:0]   expq [$];
    bit                 bp_en = 1'b0;

    logic [REC_W-1:0]   mon_exp;
    logic [REC_W-1:0]   hold_data;
    bit                 hold_v = 1'b0;

    milestone_reporter #(.CNT_W(CNT_W), .STEP(200000), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt       (cnt),
        .milestone (milestone),
        .done      (done),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_data  (rec_data),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .seq_err   (seq_err),
        .finished  (finished)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Monitor: compare every accepted record, and check the head holds under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", {31'd0, rec_valid}, 32'd1);
                chk("hold_data", {9'd0, rec_data}, {9'd0, hold_data});
            end
            hold_v = 1'b0;
            if (rec_valid && rec_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rec actual=%0h required=none", rec_data);
                end else begin
                    mon_exp = expq.pop_front();
                    chk("rec_data", {9'd0, rec_data}, {9'd0, mon_exp});
                end
            end else if (rec_valid) begin
                hold_v    = 1'b1;
                hold_data = rec_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_en) rec_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic ev(input logic [CNT_W-1:0] c, input bit pushed, input logic [2:0] s);
        cnt       = c;
        milestone = 1'b1;
        if (pushed) expq.push_back({s, c});
        tick();
        milestone = 1'b0;
        tick();
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        milestone = 1'b0;
        done      = 1'b0;
        rec_ready = 1'b0;
        expq.delete();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while (rec_valid && n < 200) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, rec_valid}, 32'd0);
        chk({nm, "_sb"}, expq.size(), 32'd0);
    endtask

    task automatic wait_finished(input string nm);
        int n;
        n = 0;
        while (!finished && n < 10) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, finished}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] s;
        logic [CNT_W-1:0] c;

        // Reset state
        do_reset(2);
        chk("rst_valid", {31'd0, rec_valid}, 32'd0);
        chk("rst_data", {9'd0, rec_data}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("rst_seq_err", {31'd0, seq_err}, 32'd0);
        chk("rst_finished", {31'd0, finished}, 32'd0);

        // Nominal milestones, one-cycle latency
        rec_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            c         = 20'(i * 200000);
            cnt       = c;
            milestone = 1'b1;
            expq.push_back({3'(i), c});
            tick();
            chk("lat_valid", {31'd0, rec_valid}, 32'd1);
            chk("lat_data", {9'd0, rec_data}, {9'd0, 3'(i), c});
            milestone = 1'b0;
            tick();
        end
        chk("nom_seq_err", {31'd0, seq_err}, 32'd0);

        // Milestone and done rise together and stay high
        cnt       = 20'd1000000;
        milestone = 1'b1;
        done      = 1'b1;
        expq.push_back({3'd5, 20'd1000000});
        tick();
        chk("done_valid", {31'd0, rec_valid}, 32'd1);
        chk("done_finished_early", {31'd0, finished}, 32'd0);
        wait_finished("done_finished");
        chk("done_empty", {31'd0, rec_valid}, 32'd0);
        chk("done_sb", expq.size(), 32'd0);
        chk("done_seq_err", {31'd0, seq_err}, 32'd0);
        // Events in FIN are ignored
        milestone = 1'b0;
        tick();
        milestone = 1'b1;
        tick();
        tick();
        chk("fin_ignore", {31'd0, rec_valid}, 32'd0);
        milestone = 1'b0;

        // Overflow with DEPTH=4
        do_reset(1);
        ev(20'd200000, 1'b1, 3'd1);
        ev(20'd400000, 1'b1, 3'd2);
        ev(20'd600000, 1'b1, 3'd3);
        ev(20'd800000, 1'b1, 3'd4);
        chk("full_no_overflow", {31'd0, overflow}, 32'd0);
        ev(20'd1000000, 1'b0, 3'd5);
        ev(20'd5, 1'b0, 3'd6);
        chk("ovf_overflow", {31'd0, overflow}, 32'd1);
        chk("ovf_drop_cnt", {24'd0, drop_cnt}, 32'd2);
        chk("ovf_head", {9'd0, rec_data}, {9'd0, 3'd1, 20'd200000});
        // Full FIFO with a same-cycle pop: push accepted
        cnt       = 20'd7;
        milestone = 1'b1;
        rec_ready = 1'b1;
        expq.push_back({3'd7, 20'd7});
        tick();
        milestone = 1'b0;
        tick();
        chk("full_pop_push_drop", {24'd0, drop_cnt}, 32'd2);
        ev(20'd9, 1'b1, 3'd0);   // seq wraps 7 -> 0
        wait_empty("ovf_drain");
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Drop counter saturation
        do_reset(1);
        for (int i = 0; i < 4; i++) ev(20'(i + 1), 1'b1, 3'(i + 1));
        for (int i = 0; i < 260; i++) ev(20'(100 + i), 1'b0, 3'd0);
        chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
        rec_ready = 1'b1;
        wait_empty("sat_drain");

        // Spacing violation is sticky, records still delivered
        do_reset(1);
        rec_ready = 1'b1;
        ev(20'd200000, 1'b1, 3'd1);
        chk("space_ok", {31'd0, seq_err}, 32'd0);
        ev(20'd500000, 1'b1, 3'd2);
        chk("space_err", {31'd0, seq_err}, 32'd1);
        ev(20'd700000, 1'b1, 3'd3);
        chk("space_sticky", {31'd0, seq_err}, 32'd1);
        wait_empty("space_drain");

        // Random backpressure, bursts that fit in the FIFO
        do_reset(1);
        bp_en = 1'b1;
        s     = 3'd1;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++) begin
                ev(20'(1000 + b * 10 + k), 1'b1, s);
                s = s + 3'd1;
            end
            wait_empty("bp_burst");
        end
        bp_en     = 1'b0;
        rec_ready = 1'b0;
        chk("bp_no_drop", {24'd0, drop_cnt}, 32'd0);

        // Reset in DRAIN with two records queued, milestone held through release
        do_reset(1);
        ev(20'd200000, 1'b1, 3'd1);
        ev(20'd400000, 1'b1, 3'd2);
        done = 1'b1;
        tick();
        tick();
        chk("drain_valid", {31'd0, rec_valid}, 32'd1);
        rst_n = 1'b0;
        expq.delete();
        done      = 1'b0;
        cnt       = 20'd200000;
        milestone = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, rec_valid}, 32'd0);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
        chk("mid_rst_seq_err", {31'd0, seq_err}, 32'd0);
        chk("mid_rst_finished", {31'd0, finished}, 32'd0);
        rst_n     = 1'b1;
        rec_ready = 1'b1;
        expq.push_back({3'd1, 20'd200000});
        tick();
        chk("rel_valid", {31'd0, rec_valid}, 32'd1);
        chk("rel_data", {9'd0, rec_data}, {9'd0, 3'd1, 20'd200000});
        milestone = 1'b0;
        wait_empty("rel_drain");
        tick();
        chk("rel_run_state", {31'd0, finished}, 32'd0);
        done = 1'b1;
        tick();
        wait_finished("rel_finished");

        chk("final_sb", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
